// File: rtl/pixlcd_3wire_rx.sv
// Display-side receiver for the 3-wire pixel LCD serial bus: oversamples the
// bus, deserialises MSB-first words, decodes page/column commands, writes data.
module pixlcd_3wire_rx #(
  parameter int MAIN_CLK  = 27_000_000,
  parameter int BITS      = 8,
  parameter int LCD_COLS  = 128,
  parameter int LCD_PAGES = 8,
  parameter int ADDR_BITS = $clog2(LCD_COLS * LCD_PAGES)
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_lcd_cs,
  input  logic                         in_lcd_reset,
  input  logic                         in_lcd_regsel,
  input  logic                         in_lcd_scl,
  input  logic                         in_lcd_sda,
  output logic [ADDR_BITS-1:0]         out_mem_addr,
  output logic [BITS-1:0]              out_mem_word,
  output logic                         out_mem_write,
  output logic [BITS-1:0]              out_cmd,
  output logic                         out_cmd_valid,
  output logic [$clog2(LCD_PAGES)-1:0] out_page,
  output logic [7:0]                   out_col,
  output logic                         out_frame_err
);

  localparam int PAGE_BITS = $clog2(LCD_PAGES);
  localparam int CNT_BITS  = $clog2(BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(BITS - 1);
  localparam logic [8:0]          COL_LIM  = 9'(LCD_COLS);

  if (MAIN_CLK < 8) begin : g_clk_check
    $error("MAIN_CLK must allow at least 8 samples per bus clock");
  end

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  state_t              state;
  logic [1:0]          cs_q, lrst_q, rs_q, scl_q, sda_q;
  logic                scl_prev;
  logic [BITS-2:0]     shift;
  logic [CNT_BITS-1:0] count;

  logic cs_s, lrst_s, rs_s, scl_s, sda_s, scl_rise;
  logic [BITS-1:0] word;

  assign cs_s     = cs_q[1];
  assign lrst_s   = lrst_q[1];
  assign rs_s     = rs_q[1];
  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_prev;
  assign word     = {shift, sda_s};

  // Synchronisers idle at the bus-inactive levels so reset never fakes a cs fall.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cs_q     <= '1;
      lrst_q   <= '1;
      rs_q     <= '0;
      scl_q    <= '0;
      sda_q    <= '0;
      scl_prev <= 1'b0;
    end else begin
      cs_q     <= {cs_q[0], in_lcd_cs};
      lrst_q   <= {lrst_q[0], in_lcd_reset};
      rs_q     <= {rs_q[0], in_lcd_regsel};
      scl_q    <= {scl_q[0], in_lcd_scl};
      sda_q    <= {sda_q[0], in_lcd_sda};
      scl_prev <= scl_s;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state         <= IDLE;
      shift         <= '0;
      count         <= '0;
      out_mem_addr  <= '0;
      out_mem_word  <= '0;
      out_mem_write <= 1'b0;
      out_cmd       <= '0;
      out_cmd_valid <= 1'b0;
      out_page      <= '0;
      out_col       <= '0;
      out_frame_err <= 1'b0;
    end else if (!lrst_s) begin
      state         <= IDLE;
      shift         <= '0;
      count         <= '0;
      out_mem_addr  <= '0;
      out_mem_word  <= '0;
      out_mem_write <= 1'b0;
      out_cmd_valid <= 1'b0;
      out_page      <= '0;
      out_col       <= '0;
      out_frame_err <= 1'b0;
    end else begin
      out_mem_write <= 1'b0;
      out_cmd_valid <= 1'b0;
      out_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (!cs_s) state <= RECV;
        end
        RECV: begin
          // The final edge wins over a simultaneous cs rise; decode happens here
          // so the strobes are visible during the single COMMIT cycle.
          if (scl_rise && count == LAST_BIT) begin
            state <= COMMIT;
            count <= '0;
            shift <= {shift[BITS-3:0], sda_s};
            if (rs_s) begin
              if ({1'b0, out_col} < COL_LIM) begin
                out_mem_addr  <= ADDR_BITS'(out_page) * ADDR_BITS'(LCD_COLS)
                               + ADDR_BITS'(out_col);
                out_mem_word  <= word;
                out_mem_write <= 1'b1;
                out_col       <= ({1'b0, out_col} == COL_LIM - 9'd1) ? '0 : out_col + 8'd1;
              end
            end else begin
              out_cmd       <= word;
              out_cmd_valid <= 1'b1;
              case (word[7:4])
                4'hB: if (int'(word[3:0]) < LCD_PAGES) out_page <= PAGE_BITS'(word[3:0]);
                4'h1: out_col[7:4] <= word[3:0];
                4'h0: out_col[3:0] <= word[3:0];
                default: ;
              endcase
            end
          end else if (cs_s) begin
            state <= IDLE;
            count <= '0;
            if (count != '0) out_frame_err <= 1'b1;
          end else if (scl_rise) begin
            shift <= {shift[BITS-3:0], sda_s};
            count <= count + CNT_BITS'(1);
          end
        end
        COMMIT: begin
          if (cs_s) begin
            state <= IDLE;
            count <= '0;
          end else begin
            state <= RECV;
            if (scl_rise) begin
              shift <= {shift[BITS-3:0], sda_s};
              count <= CNT_BITS'(1);
            end else begin
              count <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixlcd_3wire_rx.sv
// Self-checking bench for pixlcd_3wire_rx: command/data vector table plus
// hand-written corner sequences, with a write/command scoreboard.
module tb_pixlcd_3wire_rx;

  logic       clk = 1'b0;
  logic       rst, cs, lrst, rs, scl, sda;
  logic [9:0] mem_addr;
  logic [7:0] mem_word, cmd, col;
  logic       mem_write, cmd_valid, frame_err;
  logic [2:0] page;

  int checks = 0;
  int fails  = 0;
  int err_exp = 0;
  logic [17:0] wq[$];
  logic [7:0]  cq[$];
  logic prev_wr = 1'b0;

  always #5 clk = ~clk;

  pixlcd_3wire_rx #(.MAIN_CLK(27_000_000), .BITS(8), .LCD_COLS(128), .LCD_PAGES(8)) dut (
    .in_clk(clk), .in_rst(rst), .in_lcd_cs(cs), .in_lcd_reset(lrst),
    .in_lcd_regsel(rs), .in_lcd_scl(scl), .in_lcd_sda(sda),
    .out_mem_addr(mem_addr), .out_mem_word(mem_word), .out_mem_write(mem_write),
    .out_cmd(cmd), .out_cmd_valid(cmd_valid), .out_page(page), .out_col(col),
    .out_frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_write) begin
      check("write_strobe_width", 32'(prev_wr), 32'd0);
      checks++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0d word %0h, none expected", mem_addr, mem_word);
      end else begin
        logic [17:0] e;
        e = wq.pop_front();
        if ({mem_addr, mem_word} !== e) begin
          fails++;
          $display("FAIL write: got addr %0d word %0h expected addr %0d word %0h",
                   mem_addr, mem_word, e[17:8], e[7:0]);
        end
      end
    end
    prev_wr = mem_write;
    if (cmd_valid) begin
      checks++;
      if (cq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cmd: got %0h, none expected", cmd);
      end else begin
        logic [7:0] c;
        c = cq.pop_front();
        if (cmd !== c) begin
          fails++;
          $display("FAIL cmd: got %0h expected %0h", cmd, c);
        end
      end
    end
    if (frame_err) begin
      checks++;
      if (err_exp == 0) begin
        fails++;
        $display("FAIL unexpected_frame_err: got 1 expected 0");
      end else err_exp--;
    end
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic r, input logic [7:0] d, input int unsigned n);
    rs = r;
    for (int unsigned i = 0; i < n; i++) begin
      scl = 1'b0;
      sda = d[7-i];
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic check_regs(input string name, input logic [2:0] p, input logic [7:0] c);
    wait_clk(3);
    @(negedge clk);
    check({name, "_page"}, 32'(page), 32'(p));
    check({name, "_col"}, 32'(col), 32'(c));
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       wr;
    logic [9:0] addr;
    logic [2:0] pg;
    logic [7:0] cl;
  } vec_t;

  vec_t vecs[17];
  int   lat;

  initial begin
    vecs[0]  = '{1'b0, 8'hB3, 1'b0, 10'd0,   3'd3, 8'h00};
    vecs[1]  = '{1'b0, 8'h12, 1'b0, 10'd0,   3'd3, 8'h20};
    vecs[2]  = '{1'b0, 8'h05, 1'b0, 10'd0,   3'd3, 8'h25};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 10'd421, 3'd3, 8'h26};
    vecs[4]  = '{1'b0, 8'hB2, 1'b0, 10'd0,   3'd2, 8'h26};
    vecs[5]  = '{1'b0, 8'h17, 1'b0, 10'd0,   3'd2, 8'h76};
    vecs[6]  = '{1'b0, 8'h0F, 1'b0, 10'd0,   3'd2, 8'h7F};
    vecs[7]  = '{1'b1, 8'h81, 1'b1, 10'd383, 3'd2, 8'h00};
    vecs[8]  = '{1'b1, 8'h7E, 1'b1, 10'd256, 3'd2, 8'h01};
    vecs[9]  = '{1'b0, 8'hB9, 1'b0, 10'd0,   3'd2, 8'h01};
    vecs[10] = '{1'b0, 8'h19, 1'b0, 10'd0,   3'd2, 8'h91};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 10'd0,   3'd2, 8'h90};
    vecs[12] = '{1'b1, 8'h11, 1'b0, 10'd0,   3'd2, 8'h90};
    vecs[13] = '{1'b0, 8'hAF, 1'b0, 10'd0,   3'd2, 8'h90};
    vecs[14] = '{1'b0, 8'hB7, 1'b0, 10'd0,   3'd7, 8'h90};
    vecs[15] = '{1'b0, 8'h10, 1'b0, 10'd0,   3'd7, 8'h00};
    vecs[16] = '{1'b1, 8'h3C, 1'b1, 10'd896, 3'd7, 8'h01};

    rst = 1'b1; cs = 1'b1; lrst = 1'b1; rs = 1'b0; scl = 1'b0; sda = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(4);
    @(negedge clk);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_word", 32'(mem_word), 0);
    check("rst_write", 32'(mem_write), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_page", 32'(page), 0);
    check("rst_col", 32'(col), 0);
    check("rst_frame_err", 32'(frame_err), 0);

    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 17; i++) begin
      if (!vecs[i].r) cq.push_back(vecs[i].d);
      if (vecs[i].wr) wq.push_back({vecs[i].addr, vecs[i].d});
      send_bits(vecs[i].r, vecs[i].d, 8);
      check_regs($sformatf("vec%0d", i), vecs[i].pg, vecs[i].cl);
    end

    // Pin-edge-to-strobe latency on the final bit.
    wq.push_back({10'd897, 8'h5A});
    send_bits(1'b1, 8'h5A, 7);
    scl = 1'b0; sda = 1'b0;
    wait_clk(4);
    scl = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_write) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat < 3 || lat > 4) begin
      fails++;
      $display("FAIL latency: got %0d clocks expected 3..4 (0 = timeout)", lat);
    end
    check_regs("lat", 3'd7, 8'h02);

    // cs rises together with the final edge: word accepted, no error.
    wq.push_back({10'd898, 8'hC3});
    send_bits(1'b1, 8'hC3, 7);
    scl = 1'b0; sda = 1'b1;
    wait_clk(4);
    scl = 1'b1; cs = 1'b1;
    check_regs("cs_last_edge", 3'd7, 8'h03);
    wait_clk(4);

    // cs deasserted after 5 bits.
    cs = 1'b0;
    wait_clk(4);
    send_bits(1'b1, 8'hFF, 5);
    err_exp++;
    cs = 1'b1;
    wait_clk(8);
    check("frame_err_seen", 32'(err_exp), 0);
    cs = 1'b0;
    wait_clk(4);
    wq.push_back({10'd899, 8'h66});
    send_bits(1'b1, 8'h66, 8);
    check_regs("after_err", 3'd7, 8'h04);

    // scl toggling while deselected.
    cs = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 16; i++) begin
      scl = ~scl; sda = ~sda;
      wait_clk(4);
    end
    scl = 1'b0;
    check_regs("scl_cs_high", 3'd7, 8'h04);

    // Display reset during a transfer.
    cs = 1'b0;
    wait_clk(4);
    cq.push_back(8'hB5);
    send_bits(1'b0, 8'hB5, 8);
    send_bits(1'b0, 8'h12, 4);
    lrst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      scl = ~scl;
      wait_clk(4);
    end
    scl = 1'b0; cs = 1'b1;
    wait_clk(4);
    lrst = 1'b1;
    wait_clk(4);
    @(negedge clk);
    check("lrst_page", 32'(page), 0);
    check("lrst_col", 32'(col), 0);
    check("lrst_cmd_hold", 32'(cmd), 32'hB5);
    check("lrst_addr", 32'(mem_addr), 0);

    // Synchronous reset mid-word.
    cs = 1'b0;
    wait_clk(4);
    cq.push_back(8'hB1);
    send_bits(1'b0, 8'hB1, 8);
    wq.push_back({10'd128, 8'h44});
    send_bits(1'b1, 8'h44, 8);
    send_bits(1'b1, 8'hAA, 3);
    scl = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd", 32'(cmd), 0);
    check("midrst_page", 32'(page), 0);
    check("midrst_col", 32'(col), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_word", 32'(mem_word), 0);
    cs = 1'b1;
    wait_clk(6);
    cs = 1'b0;
    wait_clk(4);
    wq.push_back({10'd0, 8'h99});
    send_bits(1'b1, 8'h99, 8);
    check_regs("post_rst", 3'd0, 8'h01);
    cs = 1'b1;
    wait_clk(8);

    check("writes_left", 32'(wq.size()), 0);
    check("cmds_left", 32'(cq.size()), 0);
    check("errs_left", 32'(err_exp), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
